// File: rtl/alu_pkg.sv
// Shared definitions for the EX-stage ALU control/execute slice.
// Holds the ALU control codes, the R-type funct values, the ALUOp
// encodings, the decoder result payload and the executor FSM state.
package alu_pkg;

  localparam int unsigned CTRL_W  = 3;
  localparam int unsigned FUNCT_W = 6;
  localparam int unsigned ALUOP_W = 2;

  // ALU control codes driven towards the datapath and the hazard unit.
  typedef enum logic [CTRL_W-1:0] {
    CTRL_AND = 3'b000,
    CTRL_OR  = 3'b001,
    CTRL_ADD = 3'b010,
    CTRL_ILL = 3'b011,
    CTRL_SUB = 3'b110,
    CTRL_MUL = 3'b111
  } alu_ctrl_e;

  // R-type funct field values that have a defined operation.
  localparam logic [FUNCT_W-1:0] FUNCT_ADD = 6'b100000;
  localparam logic [FUNCT_W-1:0] FUNCT_SUB = 6'b100010;
  localparam logic [FUNCT_W-1:0] FUNCT_MUL = 6'b011000;
  localparam logic [FUNCT_W-1:0] FUNCT_AND = 6'b100100;
  localparam logic [FUNCT_W-1:0] FUNCT_OR  = 6'b100101;

  // ALUOp encodings coming from the main control unit.
  typedef enum logic [ALUOP_W-1:0] {
    ALUOP_RTYPE = 2'b00,
    ALUOP_OR    = 2'b01,
    ALUOP_ADD   = 2'b10,
    ALUOP_SUB   = 2'b11
  } alu_op_e;

  // Decoder output payload.
  typedef struct packed {
    alu_ctrl_e ctrl;
    logic      illegal;
  } alu_dec_t;

  // Executor FSM state.
  typedef enum logic {
    IDLE = 1'b0,
    MUL  = 1'b1
  } alu_state_e;

endpackage : alu_pkg

// File: rtl/alu_ctrl_exec_if.sv
// Request/response bundle between the ID/EX register and the ALU executor.
// master: the pipeline side (drives request, flush, operands).
// slave : the executor (drives ready and the registered result fields).
interface alu_ctrl_exec_if #(
  parameter int unsigned WIDTH = 32
);
  import alu_pkg::*;

  logic               valid_i;
  logic               ready_o;
  logic               flush_i;
  logic [FUNCT_W-1:0] funct_i;
  logic [ALUOP_W-1:0] ALUOp_i;
  logic [WIDTH-1:0]   a_i;
  logic [WIDTH-1:0]   b_i;
  logic               valid_o;
  logic [WIDTH-1:0]   result_o;
  logic               zero_o;
  logic [CTRL_W-1:0]  ALUCtrl_o;
  logic               illegal_o;

  modport master (
    output valid_i, flush_i, funct_i, ALUOp_i, a_i, b_i,
    input  ready_o, valid_o, result_o, zero_o, ALUCtrl_o, illegal_o
  );

  modport slave (
    input  valid_i, flush_i, funct_i, ALUOp_i, a_i, b_i,
    output ready_o, valid_o, result_o, zero_o, ALUCtrl_o, illegal_o
  );

endinterface : alu_ctrl_exec_if

// File: rtl/alu_decode.sv
// Pure combinational ALUOp/funct -> ALU control decoder.
// Ports: alu_op_i (ALUOp), funct_i (R-type funct), dec_o (ctrl + illegal).
// Every input combination is assigned, so no storage is inferred.
module alu_decode
  import alu_pkg::*;
(
  input  logic [ALUOP_W-1:0] alu_op_i,
  input  logic [FUNCT_W-1:0] funct_i,
  output alu_dec_t           dec_o
);

  always_comb begin
    dec_o.ctrl    = CTRL_ILL;
    dec_o.illegal = 1'b0;
    case (alu_op_e'(alu_op_i))
      ALUOP_OR:  dec_o.ctrl = CTRL_OR;
      ALUOP_ADD: dec_o.ctrl = CTRL_ADD;
      ALUOP_SUB: dec_o.ctrl = CTRL_SUB;
      default: begin
        case (funct_i)
          FUNCT_ADD: dec_o.ctrl = CTRL_ADD;
          FUNCT_SUB: dec_o.ctrl = CTRL_SUB;
          FUNCT_MUL: dec_o.ctrl = CTRL_MUL;
          FUNCT_AND: dec_o.ctrl = CTRL_AND;
          FUNCT_OR:  dec_o.ctrl = CTRL_OR;
          default: begin
            dec_o.ctrl    = CTRL_ILL;
            dec_o.illegal = 1'b1;
          end
        endcase
      end
    endcase
  end

endmodule : alu_decode

// File: rtl/alu_ctrl_exec.sv
// EX-stage ALU: decodes ALUOp/funct and executes on WIDTH-bit operands
// behind a valid/ready handshake. and/or/add/sub/illegal finish in one
// cycle; mul is an unsigned shift-add sequence over WIDTH cycles.
// Ports: clk_i (rising edge), rst_i (async, active low),
//        bus (slave modport: request, flush, operands, result fields).
module alu_ctrl_exec
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  alu_ctrl_exec_if.slave        bus
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  alu_state_e       state_q, state_d;
  logic             ready_q, ready_d;
  logic             valid_q, valid_d;
  logic             illegal_q, illegal_d;
  logic             zero_q, zero_d;
  alu_ctrl_e        ctrl_q, ctrl_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  alu_dec_t         dec;
  logic [WIDTH-1:0] op_result;
  logic [WIDTH-1:0] acc_step;
  logic             accept;

  alu_decode u_decode (
    .alu_op_i (bus.ALUOp_i),
    .funct_i  (bus.funct_i),
    .dec_o    (dec)
  );

  // ready_q mirrors "state is IDLE", so it is the accept qualifier.
  assign accept = bus.valid_i && ready_q && !bus.flush_i;

  // Single-cycle result; mul and illegal codes give zero here.
  always_comb begin
    op_result = '0;
    case (dec.ctrl)
      CTRL_AND: op_result = bus.a_i & bus.b_i;
      CTRL_OR:  op_result = bus.a_i | bus.b_i;
      CTRL_ADD: op_result = bus.a_i + bus.b_i;
      CTRL_SUB: op_result = bus.a_i - bus.b_i;
      default:  op_result = '0;
    endcase
  end

  // One shift-add step: accumulate the multiplicand when the multiplier LSB is set.
  always_comb begin
    acc_step = acc_q;
    if (mplier_q[0]) begin
      acc_step = acc_q + mcand_q;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d   = state_q;
    valid_d   = 1'b0;
    illegal_d = 1'b0;
    zero_d    = zero_q;
    ctrl_d    = ctrl_q;
    result_d  = result_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          if (dec.ctrl == CTRL_MUL) begin
            state_d  = MUL;
            mcand_d  = bus.a_i;
            mplier_d = bus.b_i;
            acc_d    = '0;
            cnt_d    = CNT_W'(WIDTH - 1);
          end else begin
            valid_d   = 1'b1;
            illegal_d = dec.illegal;
            ctrl_d    = dec.ctrl;
            result_d  = op_result;
            zero_d    = (op_result == '0);
          end
        end
      end
      MUL: begin
        // Flush wins over a completion landing on the same edge.
        if (bus.flush_i) begin
          state_d = IDLE;
        end else begin
          acc_d    = acc_step;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          cnt_d    = cnt_q - CNT_W'(1);
          if (cnt_q == '0) begin
            state_d  = IDLE;
            valid_d  = 1'b1;
            ctrl_d   = CTRL_MUL;
            result_d = acc_step;
            zero_d   = (acc_step == '0);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    ready_d = (state_d == IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q   <= IDLE;
      ready_q   <= 1'b1;
      valid_q   <= 1'b0;
      illegal_q <= 1'b0;
      zero_q    <= 1'b1;
      ctrl_q    <= CTRL_AND;
      result_q  <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      ready_q   <= ready_d;
      valid_q   <= valid_d;
      illegal_q <= illegal_d;
      zero_q    <= zero_d;
      ctrl_q    <= ctrl_d;
      result_q  <= result_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
    end
  end

  assign bus.ready_o   = ready_q;
  assign bus.valid_o   = valid_q;
  assign bus.illegal_o = illegal_q;
  assign bus.zero_o    = zero_q;
  assign bus.ALUCtrl_o = ctrl_q;
  assign bus.result_o  = result_q;

endmodule : alu_ctrl_exec

// File: doc/alu_ctrl_exec.md
# alu_ctrl_exec

Parametrised successor to the combinational ALU control decoder. It decodes ALUOp/funct into a 3-bit ALU control code and executes the operation on WIDTH-bit operands behind a valid/ready handshake. Add, sub, and, or complete in one cycle. Multiply runs as an iterative shift-add sequence over WIDTH cycles. It sits in the EX stage between the ID/EX pipeline register and EX/MEM.

## Interface
Parameters:
- WIDTH, 32, operand/result width (≥ 4)

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  asynchronous, active-low reset
- valid_i  in  1  request present
- ready_o  out  1  unit can accept request
- flush_i  in  1  synchronous abort of in-flight op
- funct_i  in  6  R-type funct field
- ALUOp_i  in  2  00 R-type, 01 or, 10 add, 11 sub
- a_i  in  WIDTH  operand A
- b_i  in  WIDTH  operand B
- valid_o  out  1  result valid, one-cycle pulse
- result_o  out  WIDTH  result, held until next valid_o
- zero_o  out  1  result_o == 0
- ALUCtrl_o  out  3  decoded control of the current result
- illegal_o  out  1  undefined funct on R-type, pulses with valid_o

## Operation
- **Decode (combinational, at accept).**
  - ALUOp 01→001 (or), 10→010 (add), 11→110 (sub).
  - ALUOp 00 decodes funct:
    - 100000→010 (add)
    - 100010→110 (sub)
    - 011000→111 (mul)
    - 100100→000 (and)
    - 100101→001 (or)
  - Any other funct → illegal: result 0, ALUCtrl 011, illegal_o=1. No latch; the decoder is fully specified.
- **Accept.** A request is accepted on a rising edge when valid_i && ready_o && !flush_i.
- **FSM states.**
  - IDLE: ready_o=1.
  - MUL: ready_o=0.
- **Single-cycle ops (and, or, add, sub, illegal).**
  - Result is registered at the accept edge; valid_o=1 for the following cycle.
  - FSM stays in IDLE, so back-to-back accepts give one result per cycle.
- **Mul (IDLE→MUL).**
  - Capture multiplicand=a_i, multiplier=b_i, acc=0, count=WIDTH-1.
  - Each MUL cycle: if multiplier[0], acc += multiplicand (mod 2^WIDTH). Then multiplicand <<= 1, multiplier >>= 1, count--.
  - On the edge where count==0: result_o←final acc, valid_o=1 next cycle, FSM→IDLE.
  - Product is the low WIDTH bits, unsigned (equal to the low bits of the signed product).
- **Arithmetic.** Add and sub wrap modulo 2^WIDTH; there are no overflow flags. zero_o is computed from the registered result.
- **Flush.**
  - flush_i in MUL: FSM→IDLE next edge, no valid_o, result_o/ALUCtrl_o unchanged.
  - flush_i in IDLE: suppresses accept.
  - flush_i has priority over completion on the same edge.
- **Hold.** result_o, zero_o and ALUCtrl_o hold their last values when valid_o=0.

## Timing
- Reset (rst_i low, async): FSM=IDLE, ready_o=1, valid_o=0, result_o=0, zero_o=1, ALUCtrl_o=000, illegal_o=0, count=0, acc=0.
- Reset asserted mid-MUL aborts immediately; no valid_o after release.
- Latency (accept edge to valid_o high):
  - Single-cycle ops: 1 cycle.
  - Mul: WIDTH cycles; ready_o is low for exactly WIDTH cycles after accept.
- ready_o returns high in the same cycle valid_o pulses, so a new request can be accepted in that cycle.
- valid_o is never high for two consecutive cycles from a single request.
- Inputs are sampled only at the accept edge. funct_i, a_i and b_i may change during MUL without effect.

## Structure
- Shared package (alu_pkg) holds:
  - ALUCtrl codes: CTRL_AND=000, OR=001, ADD=010, ILL=011, SUB=110, MUL=111.
  - funct constants.
  - ALUOp encodings.
  - FSM state enum {IDLE, MUL}.
- One sub-module: alu_decode (pure combinational funct/ALUOp→ctrl+illegal), reusable by the hazard unit.
- The shift-add datapath stays inline.

## Test plan
WIDTH=8 throughout.
- Reset: assert rst_i low mid-cycle → all outputs immediately at reset values, ready_o=1.
- Back-to-back ops:
  - ALUOp=10, a=0xF0, b=0x20 → valid_o next cycle, result 0x10.
  - Then ALUOp=11, a=5, b=5 → result 0, zero_o=1, ALUCtrl 110.
  - The two results are on consecutive cycles.
- Mul: funct=011000, a=13, b=11 → ready_o low 8 cycles, valid_o at cycle 8, result 0x8F, ALUCtrl 111. A new add is accepted in the valid_o cycle.
- Illegal: ALUOp=00, funct=101010 → result 0, illegal_o=1, ALUCtrl 011 for one cycle.
- Flush: start mul 0xFF×0xFF, assert flush_i at cycle 4 → no valid_o, ready_o=1 next cycle, result_o keeps its previous value.
- Async reset mid-MUL at cycle 3 → FSM IDLE. Then mul 3×4 → 12 after 8 cycles.
